y86_imem_responder: RTL

//   Instruction-memory responder serving the fetch side of the Y86-64 core.

---
 rtl/y86_imem_responder.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/y86_imem_responder.sv
// y86_imem_responder
// Instruction-memory responder for the Y86-64 fetch stage. A request carries
// a PC; after LAT cycles the responder presents the 10-byte instruction
// window starting at that PC, plus an error flag when the window runs past
// the end of memory. A byte-wide load port fills program memory before a run.
//
// Parameters
//   MEM_BYTES : memory size in bytes (>= 10)
//   LAT       : cycles from request acceptance to rsp_valid (>= 1)
//
// Ports
//   clk, rst_n        : rising-edge clock, asynchronous active-low reset
//   load_en/addr/data : synchronous byte write into program memory
//   load_drop         : one-cycle pulse when a load was discarded
//   req_valid/ready   : fetch request handshake, req_pc is the fetch PC
//   rsp_valid/ready   : response handshake
//   rsp_byte          : rsp_byte[8k+7:8k] = mem[pc+k], k = 0..9
//   rsp_imem_err      : window not fully inside memory
//
// Configuration macro
//   IMEM_LOAD_PROTECT_EN : when defined, loads arriving while a fetch is in
//   flight (BUSY or RESP) are discarded and reported on load_drop. When
//   undefined, loads always apply and load_drop is tied low.
module y86_imem_responder #(
    parameter int MEM_BYTES = 1024,
    parameter int LAT       = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_en,
    input  logic [63:0] load_addr,
    input  logic [7:0]  load_data,
    output logic        load_drop,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [63:0] req_pc,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [79:0] rsp_byte,
    output logic        rsp_imem_err
);

    localparam int AW = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
    localparam int CW = $clog2(LAT + 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [63:0]   pc_q;
    logic          req_ready_q;
    logic          rsp_valid_q;
    logic [79:0]   rsp_byte_q;
    logic          rsp_err_q;

    logic [7:0]    mem [MEM_BYTES];

    logic          load_in_range;
    logic          load_wr;
    logic [79:0]   window_d;
    logic          err_d;
    logic [64:0]   byte_addr;

    assign load_in_range = (load_addr < 64'(MEM_BYTES));

`ifdef IMEM_LOAD_PROTECT_EN
    logic load_drop_q;

    // Loads are only honoured while no fetch is in flight, so a captured
    // window always reflects memory as it was when the request was accepted.
    assign load_wr   = load_en && load_in_range && (state_q == IDLE);
    assign load_drop = load_drop_q;
`else
    assign load_wr   = load_en && load_in_range;
    assign load_drop = 1'b0;
`endif

    // Program memory is deliberately left out of reset so a loaded image
    // survives a core reset.
    always_ff @(posedge clk) begin
        if (load_wr) begin
            mem[load_addr[AW-1:0]] <= load_data;
        end
    end

    // Window assembly: the address is widened to 65 bits so a PC near 2^64
    // cannot wrap back into valid memory; out-of-range bytes read as zero.
    always_comb begin
        window_d  = '0;
        byte_addr = '0;
        for (int k = 0; k < 10; k++) begin
            byte_addr = {1'b0, pc_q} + 65'(k);
            if (byte_addr < 65'(MEM_BYTES)) begin
                window_d[8*k +: 8] = mem[byte_addr[AW-1:0]];
            end
        end
        err_d = ({1'b0, pc_q} > 65'(MEM_BYTES - 10));
    end

    // Fetch FSM with registered handshake and response outputs. The capture
    // uses the memory contents before this edge's load, so a load to the
    // same address on the capture edge returns the old byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            pc_q        <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_byte_q  <= '0;
            rsp_err_q   <= 1'b0;
`ifdef IMEM_LOAD_PROTECT_EN
            load_drop_q <= 1'b0;
`endif
        end else begin
`ifdef IMEM_LOAD_PROTECT_EN
            load_drop_q <= load_en && (state_q != IDLE);
`endif
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        pc_q        <= req_pc;
                        cnt_q       <= CW'(LAT - 1);
                        req_ready_q <= 1'b0;
                        state_q     <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_q == '0) begin
                        rsp_byte_q  <= window_d;
                        rsp_err_q   <= err_d;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    req_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign req_ready    = req_ready_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_byte     = rsp_byte_q;
    assign rsp_imem_err = rsp_err_q;

endmodule
